// File: rtl/alu_cond_exec_ctrl.sv
// Issue/commit controller for the shared ALU: an EX register that drives the ALU and
// evaluates the ARM condition against the owned NZCV flags, then a WB register toward the register file.
module alu_cond_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_opcode,
    input  logic             in_s,
    input  logic [3:0]       in_rd,
    input  logic [31:0]      in_op_a,
    input  logic [31:0]      in_op_b,
    input  logic             in_shift_c,
    output logic [31:0]      alu_operand_a,
    output logic [31:0]      alu_operand_b,
    output logic [3:0]       alu_control,
    output logic             alu_carry_in,
    output logic             alu_reset,
    input  logic [31:0]      alu_result,
    input  logic [3:0]       alu_nzcv,
    input  logic             alu_result_writeback,
    input  logic             alu_nzcv_writeback,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_CMN = 4'd11;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'd0:    pass = z;
            4'd1:    pass = !z;
            4'd2:    pass = c;
            4'd3:    pass = !c;
            4'd4:    pass = n;
            4'd5:    pass = !n;
            4'd6:    pass = v;
            4'd7:    pass = !v;
            4'd8:    pass = c && !z;
            4'd9:    pass = !c || z;
            4'd10:   pass = (n == v);
            4'd11:   pass = (n != v);
            4'd12:   pass = !z && (n == v);
            4'd13:   pass = z || (n != v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic        ex_valid;
    logic [3:0]  ex_cond;
    logic [3:0]  ex_opcode;
    logic        ex_s;
    logic [3:0]  ex_rd;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic        ex_shift_c;

    logic ex_advance;
    logic ex_pass;
    logic is_test_op;
    logic is_arith;
    logic flags_we;

    assign ex_advance = ex_valid && (!wb_valid || wb_ready);
    assign in_ready   = !ex_valid || ex_advance;
    assign ex_pass    = cond_pass(ex_cond, flags);

    // TST/TEQ/CMP/CMN always set flags regardless of the S bit
    assign is_test_op = (ex_opcode >= OP_TST) && (ex_opcode <= OP_CMN);
    assign is_arith   = ((ex_opcode >= 4'd2) && (ex_opcode <= 4'd7)) ||
                        (ex_opcode == 4'd10) || (ex_opcode == 4'd11);
    assign flags_we   = alu_nzcv_writeback && (ex_s || is_test_op);

    assign alu_operand_a = ex_op_a;
    assign alu_operand_b = ex_op_b;
    assign alu_control   = ex_opcode;
    assign alu_carry_in  = flags[1];
    assign alu_reset     = !reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ex_cond    <= '0;
            ex_opcode  <= '0;
            ex_s       <= 1'b0;
            ex_rd      <= '0;
            ex_op_a    <= '0;
            ex_op_b    <= '0;
            ex_shift_c <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                ex_valid   <= 1'b1;
                ex_cond    <= in_cond;
                ex_opcode  <= in_opcode;
                ex_s       <= in_s;
                ex_rd      <= in_rd;
                ex_op_a    <= in_op_a;
                ex_op_b    <= in_op_b;
                ex_shift_c <= in_shift_c;
            end else if (ex_advance) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Flags change on the edge the op leaves EX, so the following op is evaluated against them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            flags      <= '0;
            exec_count <= '0;
            skip_count <= '0;
        end else begin
            if (ex_advance) begin
                if (ex_pass) begin
                    exec_count <= exec_count + CNT_W'(1);
                    wb_valid   <= alu_result_writeback;
                    if (alu_result_writeback) begin
                        wb_rd   <= ex_rd;
                        wb_data <= alu_result;
                    end
                    if (flags_we) begin
                        if (is_arith) begin
                            flags <= alu_nzcv;
                        end else begin
                            flags <= {alu_nzcv[3:2], ex_shift_c, flags[0]};
                        end
                    end
                end else begin
                    skip_count <= skip_count + CNT_W'(1);
                    wb_valid   <= 1'b0;
                end
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cond_exec_ctrl.sv
// Directed bench for alu_cond_exec_ctrl with a behavioural ARM ALU model on the ALU side.
module tb_alu_cond_exec_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_cond;
    logic [3:0]       in_opcode;
    logic             in_s;
    logic [3:0]       in_rd;
    logic [31:0]      in_op_a;
    logic [31:0]      in_op_b;
    logic             in_shift_c;
    logic [31:0]      alu_operand_a;
    logic [31:0]      alu_operand_b;
    logic [3:0]       alu_control;
    logic             alu_carry_in;
    logic             alu_reset;
    logic [31:0]      alu_result;
    logic [3:0]       alu_nzcv;
    logic             alu_result_writeback;
    logic             alu_nzcv_writeback;
    logic             wb_valid;
    logic             wb_ready;
    logic [3:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_exec = '0;
    logic [CNT_W-1:0] exp_skip = '0;

    alu_cond_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s), .in_rd(in_rd),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_shift_c(in_shift_c),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_control(alu_control), .alu_carry_in(alu_carry_in), .alu_reset(alu_reset),
        .alu_result(alu_result), .alu_nzcv(alu_nzcv),
        .alu_result_writeback(alu_result_writeback), .alu_nzcv_writeback(alu_nzcv_writeback),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags(flags), .exec_count(exec_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    // Behavioural ARM ALU
    logic [31:0] ax, ay;
    logic        aci, aarith;
    logic [32:0] asum;
    always_comb begin
        ax = alu_operand_a;
        ay = alu_operand_b;
        aci = 1'b0;
        aarith = 1'b0;
        alu_result = '0;
        case (alu_control)
            4'd0, 4'd8:  alu_result = alu_operand_a & alu_operand_b;
            4'd1, 4'd9:  alu_result = alu_operand_a ^ alu_operand_b;
            4'd2, 4'd10: begin ay = ~alu_operand_b; aci = 1'b1; aarith = 1'b1; end
            4'd3:        begin ax = alu_operand_b; ay = ~alu_operand_a; aci = 1'b1; aarith = 1'b1; end
            4'd4, 4'd11: aarith = 1'b1;
            4'd5:        begin aci = alu_carry_in; aarith = 1'b1; end
            4'd6:        begin ay = ~alu_operand_b; aci = alu_carry_in; aarith = 1'b1; end
            4'd7:        begin ax = alu_operand_b; ay = ~alu_operand_a; aci = alu_carry_in; aarith = 1'b1; end
            4'd12:       alu_result = alu_operand_a | alu_operand_b;
            4'd13:       alu_result = alu_operand_b;
            4'd14:       alu_result = alu_operand_a & ~alu_operand_b;
            default:     alu_result = ~alu_operand_b;
        endcase
        asum = {1'b0, ax} + {1'b0, ay} + {32'd0, aci};
        if (aarith) alu_result = asum[31:0];
        alu_nzcv = {alu_result[31], alu_result == 32'd0,
                    aarith ? asum[32] : 1'b0,
                    aarith ? ((ax[31] == ay[31]) && (asum[31] != ax[31])) : 1'b0};
        alu_result_writeback = !((alu_control >= 4'd8) && (alu_control <= 4'd11));
        alu_nzcv_writeback = 1'b1;
    end

    task automatic send(input logic [3:0] c, input logic [3:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic sc, output int waits);
        in_cond = c; in_opcode = op; in_s = s; in_rd = rd;
        in_op_a = a; in_op_b = b; in_shift_c = sc; in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (alu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_alu_reset: got %b required 1", alu_reset); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b required 0", wb_valid); end
        reset = 1'b1;
        idle(1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        n_checks++; if (alu_reset !== 1'b0) begin n_fail++; $display("FAIL rst_alu_reset_off: got %b required 0", alu_reset); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b required 0000", flags); end
        n_checks++; if ({exec_count, skip_count} !== '0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d required 0/0", exec_count, skip_count); end
        n_checks++; if ({alu_control, alu_operand_a, alu_operand_b, wb_rd, wb_data} !== '0) begin
            n_fail++; $display("FAIL rst_regs: ctrl=%h a=%h b=%h rd=%h data=%h required all 0",
                               alu_control, alu_operand_a, alu_operand_b, wb_rd, wb_data);
        end
    endtask

    task automatic test_add();
        int w;
        send(4'd14, 4'd4, 1'b1, 4'd3, 32'd10, 32'd20, 1'b0, w);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_early: wb_valid got %b required 0", wb_valid); end
        idle(1);
        exp_exec++;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 32'd30) begin
            n_fail++; $display("FAIL add_wb: got v=%b rd=%0d data=%0d required v=1 rd=3 data=30", wb_valid, wb_rd, wb_data);
        end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b required 0000", flags); end
        n_checks++; if (exec_count !== exp_exec) begin n_fail++; $display("FAIL add_exec: got %0d required %0d", exec_count, exp_exec); end
        idle(2);
    endtask

    task automatic test_cmp_subeq();
        int w;
        send(4'd14, 4'd10, 1'b0, 4'd0, 32'd5, 32'd5, 1'b0, w);
        send(4'd0, 4'd2, 1'b0, 4'd2, 32'd30, 32'd10, 1'b0, w);
        n_checks++; if (w != 0) begin n_fail++; $display("FAIL cmp_bubble: waited %0d cycles required 0", w); end
        n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL cmp_flags: got %b required 0110", flags); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL cmp_no_wb: wb_valid got %b required 0", wb_valid); end
        idle(1);
        exp_exec += 2;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd2 || wb_data !== 32'd20) begin
            n_fail++; $display("FAIL subeq_wb: got v=%b rd=%0d data=%0d required v=1 rd=2 data=20", wb_valid, wb_rd, wb_data);
        end
        n_checks++; if (exec_count !== exp_exec) begin n_fail++; $display("FAIL subeq_exec: got %0d required %0d", exec_count, exp_exec); end
        idle(2);
    endtask

    task automatic test_cmn_addvc();
        int w;
        send(4'd14, 4'd11, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, w);
        send(4'd7, 4'd4, 1'b1, 4'd5, 32'd1, 32'd1, 1'b0, w);
        n_checks++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL cmn_flags: got %b required 1001", flags); end
        idle(1);
        exp_exec++; exp_skip++;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL addvc_wb: wb_valid got %b required 0", wb_valid); end
        n_checks++; if (skip_count !== exp_skip || exec_count !== exp_exec) begin
            n_fail++; $display("FAIL addvc_counts: got exec=%0d skip=%0d required %0d/%0d", exec_count, skip_count, exp_exec, exp_skip);
        end
        n_checks++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL addvc_flags: got %b required 1001", flags); end
        idle(2);
    endtask

    task automatic test_logical_and_carry();
        int w;
        send(4'd14, 4'd0, 1'b1, 4'd4, 32'd8, 32'd5, 1'b1, w);
        idle(1);
        exp_exec++;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd0 || wb_rd !== 4'd4) begin
            n_fail++; $display("FAIL ands_wb: got v=%b rd=%0d data=%0d required v=1 rd=4 data=0", wb_valid, wb_rd, wb_data);
        end
        n_checks++; if (flags !== 4'b0111) begin n_fail++; $display("FAIL ands_flags: got %b required 0111", flags); end
        n_checks++; if (alu_carry_in !== 1'b1) begin n_fail++; $display("FAIL carry_in: got %b required 1", alu_carry_in); end
        send(4'd14, 4'd5, 1'b0, 4'd6, 32'd1, 32'd2, 1'b0, w);
        idle(1);
        exp_exec++;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd4) begin
            n_fail++; $display("FAIL adc_wb: got v=%b data=%0d required v=1 data=4", wb_valid, wb_data);
        end
        n_checks++; if (flags !== 4'b0111) begin n_fail++; $display("FAIL adc_flags: got %b required 0111", flags); end
        idle(2);
    endtask

    // Flags are 0111 (N=0 Z=1 C=1 V=1); one MOV per condition code
    task automatic test_cond_table();
        logic [15:0] pass_mask;
        int w;
        pass_mask = 16'b0110_1010_0110_0101;
        for (int c = 0; c < 16; c++) begin
            send(c[3:0], 4'd13, 1'b0, c[3:0], 32'd0, 32'd100 + c, 1'b0, w);
            idle(1);
            if (pass_mask[c]) exp_exec++; else exp_skip++;
            n_checks++; if (wb_valid !== pass_mask[c] || (pass_mask[c] && wb_data !== 32'd100 + c)) begin
                n_fail++; $display("FAIL cond_%0d: got v=%b data=%0d required v=%b data=%0d", c, wb_valid, wb_data, pass_mask[c], 100 + c);
            end
        end
        idle(1);
        n_checks++; if (exec_count !== exp_exec || skip_count !== exp_skip) begin
            n_fail++; $display("FAIL cond_counts: got exec=%0d skip=%0d required %0d/%0d", exec_count, skip_count, exp_exec, exp_skip);
        end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        in_cond = 4'd14; in_opcode = 4'd4; in_s = 1'b0; in_shift_c = 1'b0;
        in_rd = 4'd1; in_op_a = 32'd1; in_op_b = 32'd1; in_valid = 1'b1;
        idle(1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b required 1", in_ready); end
        in_rd = 4'd2; in_op_a = 32'd2; in_op_b = 32'd2;
        idle(1);
        in_rd = 4'd3; in_op_a = 32'd3; in_op_b = 32'd3;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 4'd1 || wb_data !== 32'd2) begin
                n_fail++; $display("FAIL b2b_hold_%0d: got rdy=%b v=%b rd=%0d data=%0d required rdy=0 v=1 rd=1 data=2",
                                   i, in_ready, wb_valid, wb_rd, wb_data);
            end
            if (i < 2) idle(1);
        end
        wb_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release: in_ready got %b required 1", in_ready); end
        idle(1);
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd2 || wb_data !== 32'd4) begin
            n_fail++; $display("FAIL b2b_second: got v=%b rd=%0d data=%0d required v=1 rd=2 data=4", wb_valid, wb_rd, wb_data);
        end
        idle(1);
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 32'd6) begin
            n_fail++; $display("FAIL b2b_third: got v=%b rd=%0d data=%0d required v=1 rd=3 data=6", wb_valid, wb_rd, wb_data);
        end
        idle(1);
        exp_exec += 3;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: wb_valid got %b required 0", wb_valid); end
        n_checks++; if (exec_count !== exp_exec) begin n_fail++; $display("FAIL b2b_exec_wrap: got %0d required %0d", exec_count, exp_exec); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int w;
        wb_ready = 1'b0;
        send(4'd14, 4'd4, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
        send(4'd14, 4'd4, 1'b0, 4'd8, 32'd5, 32'd5, 1'b0, w);
        n_checks++; if (flags !== 4'b0110 || wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_preload: got flags=%b v=%b required 0110 v=1", flags, wb_valid);
        end
        reset = 1'b0;
        #1;
        n_checks++; if (wb_valid !== 1'b0 || flags !== 4'b0000 || exec_count !== '0 || skip_count !== '0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b flags=%b exec=%0d skip=%0d required 0/0000/0/0",
                               wb_valid, flags, exec_count, skip_count);
        end
        @(negedge clk);
        reset = 1'b1;
        wb_ready = 1'b1;
        exp_exec = '0; exp_skip = '0;
        idle(2);
        n_checks++; if (wb_valid !== 1'b0 || exec_count !== '0) begin
            n_fail++; $display("FAIL mid_after: got v=%b exec=%0d required v=0 exec=0", wb_valid, exec_count);
        end
        send(4'd14, 4'd4, 1'b1, 4'd3, 32'd10, 32'd20, 1'b0, w);
        idle(1);
        exp_exec++;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 32'd30 || exec_count !== exp_exec) begin
            n_fail++; $display("FAIL mid_next_op: got v=%b rd=%0d data=%0d exec=%0d required v=1 rd=3 data=30 exec=%0d",
                               wb_valid, wb_rd, wb_data, exec_count, exp_exec);
        end
        idle(2);
    endtask

    task automatic test_wrap();
        int w;
        for (int i = 0; i < 16; i++) begin
            send(4'd14, 4'd13, 1'b0, 4'd9, 32'd0, i, 1'b0, w);
            exp_exec++;
        end
        idle(2);
        n_checks++; if (exec_count !== exp_exec) begin n_fail++; $display("FAIL wrap_exec: got %0d required %0d", exec_count, exp_exec); end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        in_cond = '0; in_opcode = '0; in_s = 1'b0; in_rd = '0;
        in_op_a = '0; in_op_b = '0; in_shift_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_cmp_subeq();
        test_cmn_addvc();
        test_logical_and_carry();
        test_cond_table();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cond_exec_ctrl.md
Name: alu_cond_exec_ctrl

Overview:
Two-stage issue/commit controller that sequences the shared ALU for ARM data-processing micro-ops. It accepts an op over a valid/ready handshake and drives the ALU from its execute (EX) register. It evaluates the ARM condition field against the architectural NZCV register it owns, then commits the result to a writeback register and updates the flags. It sits between decode and the register-file write port.

Parameters:
CNT_W, 16, width of the executed-op and skipped-op statistics counters (wrap-around)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  decode presents an op
in_ready  out  1  controller accepts the op this cycle
in_cond  in  4  ARM condition field (0 EQ … 14 AL, 15 NV)
in_opcode  in  4  ALU op: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN
in_s  in  1  S bit (set flags)
in_rd  in  4  destination register index
in_op_a  in  32  first operand
in_op_b  in  32  second operand, already shifted
in_shift_c  in  1  shifter carry-out (C source for logical ops)
alu_operand_a  out  32  to ALU
alu_operand_b  out  32  to ALU
alu_control  out  4  to ALU
alu_carry_in  out  1  current C flag, to ALU (ADC/SBC/RSC)
alu_reset  out  1  active-high ALU reset, equal to !reset
alu_result  in  32  from ALU (combinational)
alu_nzcv  in  4  from ALU {N,Z,C,V}
alu_result_writeback  in  1  ALU reports that the op writes Rd
alu_nzcv_writeback  in  1  ALU reports that the op produces flags
wb_valid  out  1  writeback register holds a result
wb_ready  in  1  register file accepts the result
wb_rd  out  4  destination index
wb_data  out  32  result
flags  out  4  architectural {N,Z,C,V}
exec_count  out  CNT_W  ops whose condition passed
skip_count  out  CNT_W  ops whose condition failed

Behaviour:
- Reset (async, active-low): ex_valid=0, wb_valid=0, wb_rd=0, wb_data=0, flags=0, both counters=0, EX register cleared. alu_control=0, alu_operand_a=0, alu_operand_b=0. in_ready=1 once reset deasserts.
- Reset asserted mid-operation discards any in-flight EX and WB ops. No flag update and no counter increment occur for them.
- Stage EX: on in_valid && in_ready, capture cond, opcode, s, rd, op_a, op_b, shift_c; set ex_valid=1. ALU outputs are driven only from the EX register, never directly from in_*.
- Condition evaluation is combinational in EX against the current flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; NV 0.
- ex_advance = ex_valid && (!wb_valid || wb_ready). in_ready = !ex_valid || ex_advance. Back-to-back throughput is 1 op/cycle.
- On ex_advance with the condition passing:
  - exec_count+1.
  - If alu_result_writeback: wb_valid<=1, wb_rd<=rd, wb_data<=alu_result. Otherwise wb_valid<=0 (TST/TEQ/CMP/CMN produce no writeback).
  - Flags update when alu_nzcv_writeback && (s || opcode in 8..11). Opcodes 8..11 force S.
  - Arithmetic ops (2–7, 10, 11): flags<=alu_nzcv.
  - Logical ops (0, 1, 8, 9, 12–15): N,Z<=alu_nzcv[3:2], C<=shift_c, V unchanged.
- On ex_advance with the condition failing: skip_count+1. No writeback, flags unchanged, wb_valid<=0 unless the WB register is held.
- Flags update on the same edge the op leaves EX, so the next op in EX sees them. No hazard stall is needed.
- WB handshake: a result is consumed on wb_valid && wb_ready. Without a new commit, wb_valid<=0. While !wb_ready, wb_rd and wb_data hold stable and EX stalls; in_ready drops if EX is full.
- Latency: accept at edge N, WB register valid after edge N+1.
- Counters wrap from 2^CNT_W-1 to 0.
- alu_carry_in = flags[1] at all times.

Test Plan:
- ADD 10+20, cond AL, S=1, rd=3 -> wb_valid one cycle after accept, wb_rd=3, wb_data=30, flags=0000, exec_count=1.
- CMP 5,5 then SUBEQ 30-10 rd=2 issued back-to-back -> flags Z=1,C=1 after CMP; SUBEQ commits wb_data=20 with no bubble and no writeback from CMP.
- CMN 0x7FFFFFFF,1 then ADDVC -> flags N=1,V=1; ADDVC is skipped, skip_count=1, no wb_valid.
- ANDS 8&5 with in_shift_c=1, prior V=1 -> wb_data=0, flags N=0,Z=1,C=1,V=1 (V preserved).
- Hold wb_ready=0 for 3 cycles with 3 ops offered -> WB holds the first result stable, EX holds the second, in_ready=0. After release, results arrive in order with none lost or duplicated.
- Assert reset for 1 cycle with ops in EX and WB -> wb_valid=0, flags=0, counters=0 immediately. The next accepted op runs normally.
